// File: rtl/sb1287_drive_ctrl.sv
// sb1287_drive_ctrl: two-motor H-bridge drive with PWM speed control,
// soft-start duty ramp and forced coast dead-time on reversal.
module sb1287_drive_ctrl #(
    parameter int PWM_WIDTH   = 8,
    parameter int PWM_DIV     = 4,
    parameter int RAMP_DIV    = 1024,
    parameter int RAMP_STEP   = 8,
    parameter int DEAD_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           motion,
    input  logic [PWM_WIDTH-1:0] speed,
    output logic [3:0]           level_shift_input,
    output logic [PWM_WIDTH-1:0] duty_l,
    output logic [PWM_WIDTH-1:0] duty_r,
    output logic                 busy
);
    localparam int W  = PWM_WIDTH;
    localparam int PW = $clog2(PWM_DIV + 1);
    localparam int RW = $clog2(RAMP_DIV + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    typedef enum logic [1:0] {COAST, RUN, DEAD} mstate_t;

    logic [2:0]    motion_q;
    logic [W-1:0]  speed_q;
    logic [PW-1:0] pdiv;
    logic [W-1:0]  cnt;
    logic [RW-1:0] rdiv;
    logic          tick;

    // index 0 = left, 1 = right; dir 1 means CCW
    logic [1:0]          tgt_v, tgt_d;
    mstate_t [1:0]       st, st_n;
    logic [1:0]          dir, dir_n;
    logic [1:0][DW-1:0]  dcnt, dcnt_n;
    logic [1:0][W-1:0]   duty, duty_n;

    always_comb begin
        tgt_v = 2'b00;
        tgt_d = 2'b00;
        unique case (motion_q)
            3'd1: tgt_v = 2'b11;
            3'd2: tgt_v = 2'b10;
            3'd3: tgt_v = 2'b01;
            3'd4: begin tgt_v = 2'b11; tgt_d = 2'b11; end
            3'd5: begin tgt_v = 2'b11; tgt_d = 2'b01; end
            3'd6: begin tgt_v = 2'b11; tgt_d = 2'b10; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            motion_q <= '0;
            speed_q  <= '0;
            pdiv     <= '0;
            cnt      <= '0;
            rdiv     <= '0;
            tick     <= 1'b0;
        end else begin
            motion_q <= motion;
            speed_q  <= speed;
            if (pdiv == PW'(PWM_DIV - 1)) begin
                pdiv <= '0;
                cnt  <= cnt + 1'b1;
            end else begin
                pdiv <= pdiv + 1'b1;
            end
            if (rdiv == RW'(RAMP_DIV - 1)) begin
                rdiv <= '0;
                tick <= 1'b1;
            end else begin
                rdiv <= rdiv + 1'b1;
                tick <= 1'b0;
            end
        end
    end

    always_comb begin
        logic [W:0] sum;
        st_n   = st;
        dir_n  = dir;
        dcnt_n = dcnt;
        duty_n = duty;
        sum    = '0;
        for (int m = 0; m < 2; m++) begin
            // one extra bit so the ramp saturates instead of wrapping
            sum = {1'b0, duty[m]} + (W+1)'(RAMP_STEP);
            unique case (st[m])
                COAST: begin
                    duty_n[m] = '0;
                    if (tgt_v[m]) begin
                        st_n[m]  = RUN;
                        dir_n[m] = tgt_d[m];
                    end
                end
                RUN: begin
                    if (!tgt_v[m]) begin
                        st_n[m]   = COAST;
                        duty_n[m] = '0;
                    end else if (tgt_d[m] != dir[m]) begin
                        st_n[m]   = DEAD;
                        dir_n[m]  = tgt_d[m];
                        dcnt_n[m] = DW'(DEAD_CYCLES - 1);
                        duty_n[m] = '0;
                    end else if (duty[m] > speed_q) begin
                        duty_n[m] = speed_q;
                    end else if (tick && duty[m] < speed_q) begin
                        duty_n[m] = (sum > {1'b0, speed_q}) ?
                                    speed_q : sum[W-1:0];
                    end
                end
                DEAD: begin
                    duty_n[m] = '0;
                    dir_n[m]  = tgt_d[m];
                    if (!tgt_v[m]) begin
                        st_n[m]   = COAST;
                        dcnt_n[m] = '0;
                    end else if (dcnt[m] == '0) begin
                        st_n[m] = RUN;
                    end else begin
                        dcnt_n[m] = dcnt[m] - 1'b1;
                    end
                end
                default: begin
                    st_n[m]   = COAST;
                    duty_n[m] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= {COAST, COAST};
            dir  <= '0;
            dcnt <= '0;
            duty <= '0;
        end else begin
            st   <= st_n;
            dir  <= dir_n;
            dcnt <= dcnt_n;
            duty <= duty_n;
        end
    end

    // returns {b, a}; only one pin can ever be driven
    function automatic logic [1:0] pins(mstate_t s, logic d, logic on);
        if (s != RUN) return 2'b00;
        return d ? {on, 1'b0} : {1'b0, on};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_shift_input <= '0;
            busy              <= 1'b0;
        end else begin
            level_shift_input <= {pins(st[1], dir[1], cnt < duty[1]),
                                  pins(st[0], dir[0], cnt < duty[0])};
            busy <= (st[0] == DEAD) | (st[1] == DEAD);
        end
    end

    assign duty_l = duty[0];
    assign duty_r = duty[1];

endmodule

// File: tb/tb_sb1287_drive_ctrl.sv
// Scoreboard bench for sb1287_drive_ctrl with small timing parameters.
// Expected ramp steps are queued on stimulus and popped on duty changes.
module tb_sb1287_drive_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   motion = 3'd0;
    logic [W-1:0] speed = '0;
    logic [3:0]   lsi;
    logic [W-1:0] duty_l, duty_r;
    logic         busy;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int shoot = 0;
    int a_hits = 0;
    logic watch_a = 1'b0;

    always #5 clk = ~clk;

    sb1287_drive_ctrl #(
        .PWM_WIDTH(W), .PWM_DIV(1), .RAMP_DIV(2),
        .RAMP_STEP(4), .DEAD_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .motion(motion), .speed(speed),
        .level_shift_input(lsi), .duty_l(duty_l), .duty_r(duty_r),
        .busy(busy)
    );

    always @(negedge clk) begin
        if ((lsi[0] & lsi[1]) | (lsi[2] & lsi[3])) shoot++;
        if (watch_a && (lsi[0] | lsi[2])) a_hits++;
    end

    task automatic chk(string tag, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic ramp_push(int target);
        for (int v = 4; v < target; v += 4) exp_q.push_back(v);
        exp_q.push_back(target);
    endtask

    task automatic ramp_watch(string tag);
        int prev = duty_l;
        int last = -1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (duty_l != prev) begin
                int e = exp_q.pop_front();
                chk({tag, "_l"}, duty_l, e);
                chk({tag, "_r"}, duty_r, e);
                if (last >= 0) chk({tag, "_gap"}, c - last, 2);
                last = c;
                prev = duty_l;
            end
        end
        chk({tag, "_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic window(output int la, output int lb,
                          output int ra, output int rb);
        la = 0; lb = 0; ra = 0; rb = 0;
        repeat (16) begin
            @(negedge clk);
            la += lsi[0]; lb += lsi[1];
            ra += lsi[2]; rb += lsi[3];
        end
    endtask

    task automatic wait_busy(logic v, string tag);
        int n = 0;
        while (busy !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, v);
    endtask

    task automatic dead_len(string tag);
        int n = 0;
        int pins = 0;
        while (busy === 1'b1 && n < 40) begin
            if (lsi !== 4'b0) pins++;
            if (duty_l !== 0 || duty_r !== 0) pins++;
            n++;
            @(negedge clk);
        end
        chk({tag, "_len"}, n, 8);
        chk({tag, "_pins"}, pins, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        motion = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int la, lb, ra, rb, idle;

        repeat (2) @(negedge clk);
        chk("rst_lsi", lsi, 0);
        chk("rst_duty_l", duty_l, 0);
        chk("rst_duty_r", duty_r, 0);
        chk("rst_busy", busy, 0);

        // soft start forward
        rst_n = 1'b1; motion = 3'd1; speed = 4'd12;
        ramp_push(12);
        ramp_watch("soft");
        repeat (4) @(negedge clk);
        chk("soft_hold", duty_l, 12);
        window(la, lb, ra, rb);
        chk("soft_la", la, 12); chk("soft_ra", ra, 12);
        chk("soft_lb", lb, 0);  chk("soft_rb", rb, 0);

        // reversal
        motion = 3'd4;
        wait_busy(1'b1, "rev_busy_on");
        a_hits = 0; watch_a = 1'b1;
        dead_len("rev");
        ramp_push(12);
        ramp_watch("rev_ramp");
        window(la, lb, ra, rb);
        watch_a = 1'b0;
        chk("rev_lb", lb, 12); chk("rev_rb", rb, 12);
        chk("rev_a_hits", a_hits, 0);

        // pivot left then right
        do_reset();
        motion = 3'd5; speed = 4'd8;
        ramp_push(8);
        ramp_watch("piv");
        window(la, lb, ra, rb);
        chk("piv_la", la, 0); chk("piv_lb", lb, 8);
        chk("piv_ra", ra, 8); chk("piv_rb", rb, 0);
        motion = 3'd6;
        wait_busy(1'b1, "piv_busy_on");
        dead_len("piv");
        ramp_push(8);
        ramp_watch("piv2");
        window(la, lb, ra, rb);
        chk("piv2_la", la, 8); chk("piv2_lb", lb, 0);
        chk("piv2_ra", ra, 0); chk("piv2_rb", rb, 8);

        // stop code 7 during RUN
        motion = 3'd7;
        repeat (2) @(negedge clk);
        chk("stop_duty_l", duty_l, 0);
        chk("stop_duty_r", duty_r, 0);
        @(negedge clk);
        chk("stop_lsi", lsi, 0);

        // motion 0 during DEAD
        motion = 3'd1; speed = 4'd12;
        repeat (20) @(negedge clk);
        motion = 3'd4;
        wait_busy(1'b1, "idle_busy_on");
        motion = 3'd0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        idle = 0;
        repeat (20) begin
            @(negedge clk);
            if (lsi !== 4'b0 || duty_l !== 0 || duty_r !== 0) idle++;
        end
        chk("idle_coast", idle, 0);

        // async reset mid-RUN
        do_reset();
        motion = 3'd1; speed = 4'd15;
        repeat (40) @(negedge clk);
        chk("pre_rst_duty", duty_l, 15);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lsi", lsi, 0);
        chk("arst_duty_l", duty_l, 0);
        chk("arst_duty_r", duty_r, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized shoot-through soak
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) motion = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) speed = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        chk("shoot_through", shoot, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
